// File: rtl/aes_sbox_arbiter.sv
// Round-robin arbiter sharing one sequential sub_bytes unit between
// the round datapath (128-bit state) and the key schedule (32-bit word).
module aes_sbox_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_req_i,
    input  logic [127:0] st_data_i,
    output logic         st_ack_o,
    output logic [127:0] st_data_o,
    input  logic         ks_req_i,
    input  logic [31:0]  ks_word_i,
    output logic         ks_ack_o,
    output logic [31:0]  ks_word_o,
    output logic         sb_start_o,
    output logic [127:0] sb_s_o,
    input  logic [127:0] sb_s_i,
    input  logic         sb_done_i,
    output logic         busy_o,
    output logic         owner_o,
    output logic         timeout_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nx;
    logic          last_q;
    logic          masked_q;
    logic          st_eff;
    logic          ks_eff;
    logic          grant;
    logic          grant_ks;
    logic          expire;

    // The requester acked last is ignored for one IDLE cycle so its
    // registered request drop cannot cause a second grant.
    always_comb begin
        st_eff   = st_req_i && !(masked_q && !last_q);
        ks_eff   = ks_req_i && !(masked_q && last_q);
        grant    = st_eff || ks_eff;
        grant_ks = ks_eff && (!st_eff || !last_q);
        cnt_nx   = cnt_q + 1'b1;
        expire   = (cnt_nx == CW'(TIMEOUT_CYCLES));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (sb_done_i || expire) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o     = (state_q != IDLE);
        sb_start_o = (state_q == START);
        st_ack_o   = (state_q == RESP) && !owner_o;
        ks_ack_o   = (state_q == RESP) && owner_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            masked_q  <= 1'b0;
            owner_o   <= 1'b0;
            sb_s_o    <= '0;
            st_data_o <= '0;
            ks_word_o <= '0;
            timeout_o <= 1'b0;
        end else begin
            state_q  <= state_d;
            masked_q <= (state_q == RESP);
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        owner_o <= grant_ks;
                        sb_s_o  <= grant_ks ? {96'h0, ks_word_i}
                                            : st_data_i;
                    end
                end
                START: cnt_q <= '0;
                WAIT: begin
                    cnt_q <= cnt_nx;
                    // Done has priority over an expiring watchdog.
                    if (sb_done_i) begin
                        if (owner_o) ks_word_o <= sb_s_i[31:0];
                        else         st_data_o <= sb_s_i;
                    end else if (expire) begin
                        if (owner_o) ks_word_o <= '0;
                        else         st_data_o <= '0;
                        timeout_o <= 1'b1;
                    end
                end
                RESP:    last_q <= owner_o;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// Bench for aes_sbox_arbiter: transaction-level model with a per-cycle
// compare process, a behavioural sub_bytes stub, and a short-watchdog DUT.
module tb_aes_sbox_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   ncmp = 0;
    int   nbad = 0;
    int   lat = 1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic         st_req = 1'b0;
    logic [127:0] st_data = '0;
    logic         st_ack;
    logic [127:0] st_out;
    logic         ks_req = 1'b0;
    logic [31:0]  ks_word = '0;
    logic         ks_ack;
    logic [31:0]  ks_out;
    logic         sb_start;
    logic [127:0] sb_s;
    logic [127:0] sb_res;
    logic         sb_done;
    logic         busy;
    logic         owner;
    logic         tout;

    aes_sbox_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .st_req_i(st_req), .st_data_i(st_data),
        .st_ack_o(st_ack), .st_data_o(st_out),
        .ks_req_i(ks_req), .ks_word_i(ks_word),
        .ks_ack_o(ks_ack), .ks_word_o(ks_out),
        .sb_start_o(sb_start), .sb_s_o(sb_s),
        .sb_s_i(sb_res), .sb_done_i(sb_done),
        .busy_o(busy), .owner_o(owner), .timeout_o(tout)
    );

    logic         st2_req = 1'b0;
    logic [127:0] st2_data = '0;
    logic         st2_ack;
    logic [127:0] st2_out;
    logic         ks2_req = 1'b0;
    logic [31:0]  ks2_word = '0;
    logic         ks2_ack;
    logic [31:0]  ks2_out;
    logic         sb2_start;
    logic [127:0] sb2_s;
    logic [127:0] sb2_res;
    logic         sb2_done;
    logic         sb2_en = 1'b0;
    logic         busy2;
    logic         owner2;
    logic         tout2;

    aes_sbox_arbiter #(.TIMEOUT_CYCLES(8)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .st_req_i(st2_req), .st_data_i(st2_data),
        .st_ack_o(st2_ack), .st_data_o(st2_out),
        .ks_req_i(ks2_req), .ks_word_i(ks2_word),
        .ks_ack_o(ks2_ack), .ks_word_o(ks2_out),
        .sb_start_o(sb2_start), .sb_s_o(sb2_s),
        .sb_s_i(sb2_res), .sb_done_i(sb2_done),
        .busy_o(busy2), .owner_o(owner2), .timeout_o(tout2)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse then affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv;
        logic [7:0] s;
        inv = '0;
        for (int y = 1; y < 256; y++)
            if (gmul(b, 8'(y)) == 8'h01) inv = 8'(y);
        s = 8'h63 ^ inv;
        for (int k = 1; k < 5; k++)
            s ^= 8'((inv << k) | (inv >> (8 - k)));
        return s;
    endfunction

    function automatic logic [127:0] subbytes(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(d[8*i +: 8]);
        return r;
    endfunction

    assign sb2_res = subbytes(sb2_s);

    typedef struct {
        int           beg;
        int           ack;
        bit           who;
        logic [127:0] opnd;
        logic [127:0] res;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s @%0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    // Operation granted in IDLE cycle n with stub latency l.
    function automatic void expect_op(input bit who, input logic [127:0] d,
                                      input int n, input int l);
        exp_t e;
        e.who  = who;
        e.beg  = n + 1;
        e.ack  = n + 2 + l;
        e.opnd = who ? {96'h0, d[31:0]} : d;
        e.res  = subbytes(e.opnd);
        q.push_back(e);
    endfunction

    always @(negedge clk) begin : cmp
        bit eb;
        bit es;
        bit ea;
        eb = (q.size() > 0) && (cyc >= q[0].beg);
        es = (q.size() > 0) && (cyc == q[0].beg);
        ea = eb && (cyc == q[0].ack);
        chk("busy", busy, eb);
        chk("sb_start", sb_start, es);
        chk("timeout_flag", tout, 0);
        chk("st_ack", st_ack, ea && !q[0].who);
        chk("ks_ack", ks_ack, ea && q[0].who);
        if (eb) begin
            chk("owner", owner, q[0].who);
            chk("sb_s_hold", sb_s, q[0].opnd);
        end
        if (ea) begin
            if (q[0].who) chk("ks_word", ks_out, q[0].res[31:0]);
            else          chk("st_data", st_out, q[0].res);
            void'(q.pop_front());
        end
    end

    initial begin : stub
        logic [127:0] op;
        int c0;
        bit ab;
        sb_done = 1'b0;
        sb_res  = '0;
        forever begin
            @(negedge clk);
            if (rst_n && sb_start) begin
                op = sb_s;
                c0 = cyc;
                ab = 1'b0;
                while (cyc < c0 + lat && !ab) begin
                    @(negedge clk);
                    ab = !rst_n;
                end
                if (!ab) begin
                    sb_done = 1'b1;
                    sb_res  = subbytes(op);
                    @(negedge clk);
                    sb_done = 1'b0;
                end
            end
        end
    end

    initial begin : stub2
        bit seen;
        seen = 1'b0;
        sb2_done = 1'b0;
        forever begin
            @(negedge clk);
            sb2_done = seen && sb2_en;
            seen = sb2_start;
        end
    end

    task automatic run_req(input bit who, input logic [127:0] d);
        bit got;
        if (who) begin
            ks_word = d[31:0];
            ks_req  = 1'b1;
        end else begin
            st_data = d;
            st_req  = 1'b1;
        end
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = who ? ks_ack : st_ack;
        end
        chk(who ? "ks_ack_wait" : "st_ack_wait", got, 1);
        // Request is held through the first IDLE cycle after the ack.
        @(posedge clk);
        @(posedge clk);
        #1;
        if (who) ks_req = 1'b0;
        else     st_req = 1'b0;
    endtask

    task automatic op(input bit who, input logic [127:0] d, input int l);
        @(posedge clk);
        #1;
        lat = l;
        expect_op(who, d, cyc, l);
        run_req(who, d);
    endtask

    task automatic tie(input logic [127:0] d, input logic [31:0] w,
                       input int l);
        int n;
        @(posedge clk);
        #1;
        lat = l;
        n = cyc;
        expect_op(0, d, n, l);
        expect_op(1, {96'h0, w}, n + 2 + l + 1, l);
        fork
            run_req(0, d);
            run_req(1, {96'h0, w});
        join
    endtask

    task automatic wait_ack2(input bit who, output bit got);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = who ? ks2_ack : st2_ack;
        end
    endtask

    initial begin : main
        int n;
        bit got;
        logic [127:0] d1;
        logic [127:0] d2;
        d1 = 128'h00112233445566778899aabbccddeeff;
        d2 = 128'h3243f6a8885a308d313198a2e0370734;

        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_st_ack", st_ack, 0);
        chk("rst_ks_ack", ks_ack, 0);
        chk("rst_st_data", st_out, 0);
        chk("rst_ks_word", ks_out, 0);
        chk("rst_sb_start", sb_start, 0);
        chk("rst_sb_s", sb_s, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_timeout", tout, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        chk("model_sbox00", sbox(8'h00), 8'h63);
        chk("model_sbox53", sbox(8'h53), 8'hed);
        chk("model_subbytes", subbytes(d1),
            128'h638293c31bfc33f5c4eeacea4bc12816);

        tie(d2, 32'h01020304, 3);
        tie(d1, 32'hdeadbeef, 2);

        op(0, d1, 5);
        chk("st_literal", st_out, 128'h638293c31bfc33f5c4eeacea4bc12816);
        op(1, 128'hccddeeff, 2);
        chk("ks_literal", ks_out, 32'h4bc12816);
        op(1, 128'h0, 1);
        chk("ks_zero_literal", ks_out, 32'h63636363);

        op(0, d2, 17);
        op(1, 128'h89abcdef, 32);

        @(posedge clk);
        #1;
        lat = 17;
        n = cyc;
        expect_op(0, d1, n, 17);
        st_data = d1;
        st_req  = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        q.delete();
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_st_ack", st_ack, 0);
        chk("midrst_st_data", st_out, 0);
        chk("midrst_ks_word", ks_out, 0);
        chk("midrst_sb_s", sb_s, 0);
        st_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        op(0, d1, 4);
        chk("post_rst_literal", st_out,
            128'h638293c31bfc33f5c4eeacea4bc12816);

        @(posedge clk);
        #1;
        chk("to_flag_init", tout2, 0);
        n = cyc;
        st2_data = d1;
        st2_req  = 1'b1;
        wait_ack2(0, got);
        chk("to_ack_seen", got, 1);
        chk("to_ack_cycle", cyc, n + 10);
        chk("to_ack_data", st2_out, 0);
        chk("to_flag_set", tout2, 1);
        chk("to_owner", owner2, 0);
        @(posedge clk);
        #1 st2_req = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        sb2_en = 1'b1;
        n = cyc;
        ks2_word = 32'hccddeeff;
        ks2_req  = 1'b1;
        wait_ack2(1, got);
        chk("to_next_seen", got, 1);
        chk("to_next_cycle", cyc, n + 3);
        chk("to_next_word", ks2_out, 32'h4bc12816);
        chk("to_next_st_ack", st2_ack, 0);
        chk("to_flag_sticky", tout2, 1);
        @(posedge clk);
        #1 ks2_req = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        chk("to_flag_sticky_end", tout2, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

    initial begin : guard
        #1000000;
        $display("FAIL global_timeout @%0d: got running want finished", cyc);
        $fatal(1, "bench did not finish");
    end

endmodule
